// File: rtl/score_timer_ctrl.sv
// score_timer_ctrl: round controller for the 4-digit 7-segment display.
// Counts a BCD second timer down, accumulates a BCD hit score and resolves
// the win/lose outcome. val3..val0 are display codes: 0-9 digits, 10 'W',
// 11 'I', 12 'N', 13 '-', 14/15 blank.
// Optional feature macro: SCORE_TIMER_PAUSE_EN (start toggles a pause in RUN).
module score_timer_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int START_SEC = 30,
  parameter int WIN_SCORE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  output logic [3:0] val3,
  output logic [3:0] val2,
  output logic [3:0] val1,
  output logic [3:0] val0,
  output logic [1:0] state
);

  localparam int              TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]      START_BCD = {4'(START_SEC / 10), 4'(START_SEC % 10)};
  localparam logic [7:0]      WIN_BCD   = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = 8'h99;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-digit BCD decrement that floors at 00 (10 -> 09).
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  state_t        state_r, state_n;
  logic [7:0]    time_r, time_n;
  logic [7:0]    score_r, score_n;
  logic [TW-1:0] tick_r, tick_n;
  logic [15:0]   val_n;

  logic          tick_wrap_s;
  logic [7:0]    step_time_s;
  logic [7:0]    step_score_s;
  logic [TW-1:0] step_tick_s;
  logic          step_win_s;
  logic          step_lose_s;
  logic          run_go_s;

`ifdef SCORE_TIMER_PAUSE_EN
  logic          paused_r, paused_n;
`endif

  // One RUN-cycle update of tick, time and score, plus the exit conditions.
  always_comb begin
    tick_wrap_s  = (tick_r == TICK_LAST);
    step_time_s  = time_r;
    step_score_s = score_r;
    step_tick_s  = tick_r;
    if (tick_wrap_s) begin
      step_tick_s = {TW{1'b0}};
      step_time_s = bcd_dec(time_r);
    end else begin
      step_tick_s = tick_r + TW'(1);
    end
    if (hit) begin
      step_score_s = bcd_inc_sat(score_r);
    end else begin
      step_score_s = score_r;
    end
    // WIN outranks LOSE when the final tick and the winning hit coincide.
    step_win_s  = hit && (step_score_s == WIN_BCD);
    step_lose_s = tick_wrap_s && (step_time_s == 8'h00) && !step_win_s;
  end

  // Pause gating: a paused round (or the cycle that toggles pause) does not advance.
  always_comb begin
`ifdef SCORE_TIMER_PAUSE_EN
    run_go_s = !paused_r && !start;
`else
    run_go_s = 1'b1;
`endif
  end

  // Next-state logic and display code selection from the next state.
  always_comb begin
    state_n = state_r;
    time_n  = time_r;
    score_n = score_r;
    tick_n  = tick_r;
`ifdef SCORE_TIMER_PAUSE_EN
    paused_n = paused_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          time_n  = START_BCD;
          score_n = 8'h00;
          tick_n  = {TW{1'b0}};
`ifdef SCORE_TIMER_PAUSE_EN
          paused_n = 1'b0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef SCORE_TIMER_PAUSE_EN
        if (start) begin
          paused_n = !paused_r;
        end else begin
          paused_n = paused_r;
        end
`endif
        if (run_go_s) begin
          time_n  = step_time_s;
          score_n = step_score_s;
          tick_n  = step_tick_s;
          if (step_win_s) begin
            state_n = ST_WIN;
          end else if (step_lose_s) begin
            state_n = ST_LOSE;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start) begin
          state_n = ST_IDLE;
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_IDLE: val_n = {4'd13, 4'd13, 4'd13, 4'd13};
      ST_RUN:  val_n = {time_n, score_n};
      ST_WIN:  val_n = {4'd10, 4'd11, 4'd12, 4'd15};
      ST_LOSE: val_n = {4'd13, 4'd13, score_n};
      default: val_n = {4'd13, 4'd13, 4'd13, 4'd13};
    endcase
  end

  // State, counters and registered display codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      time_r  <= START_BCD;
      score_r <= 8'h00;
      tick_r  <= {TW{1'b0}};
      val3    <= 4'd13;
      val2    <= 4'd13;
      val1    <= 4'd13;
      val0    <= 4'd13;
`ifdef SCORE_TIMER_PAUSE_EN
      paused_r <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      time_r  <= time_n;
      score_r <= score_n;
      tick_r  <= tick_n;
      val3    <= val_n[15:12];
      val2    <= val_n[11:8];
      val1    <= val_n[7:4];
      val0    <= val_n[3:0];
`ifdef SCORE_TIMER_PAUSE_EN
      paused_r <= paused_n;
`endif
    end
  end

  assign state = state_r;

endmodule

// File: doc/score_timer_ctrl.md
# score_timer_ctrl

Game controller feeding the 4-digit 7-segment display driver: counts down a BCD second timer, accumulates a BCD hit score, and resolves the win/lose outcome. It drives the four 4-bit display codes (val3..val0) consumed directly by the display multiplexer. Code map: 0-9 are digits, 10 is W, 11 is I, 12 is N, 13 is '-', and 14/15 are blank.

## Interface
- TICK_DIV, 100_000_000: clk cycles per second tick; legal range ≥2.
- START_SEC, 30: countdown start value in seconds; legal range 1-99.
- WIN_SCORE, 10: score that wins the round; legal range 1-99.
- clk  in  1  system clock; the block uses this single clock only.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse, already debounced.
- hit  in  1  single-cycle pulse, already debounced.
- val3  out  4  leftmost display code.
- val2  out  4  display code.
- val1  out  4  display code.
- val0  out  4  rightmost display code.
- state  out  2  game state: 0 IDLE, 1 RUN, 2 WIN, 3 LOSE.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, time=START_SEC, score=0, tick counter=0, and val3..val0 = 13,13,13,13 ("----").
- IDLE:
  - Display is "----".
  - start → RUN, with time loaded to START_SEC, score=0 and tick counter=0.
  - hit is ignored.
- RUN:
  - Display val3/val2 = time tens/ones (BCD). Display val1/val0 = score tens/ones (BCD).
  - The tick counter counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and time decrements in BCD (10 → 09, not 0F).
  - hit increments score in BCD (09 → 10). Score saturates at 99.
  - start is ignored, unless SCORE_TIMER_PAUSE_EN is defined.
- Exit from RUN:
  - When the incremented score equals WIN_SCORE → WIN.
  - When the decremented time equals 00 and the win condition is not met → LOSE.
- WIN: display "WIN" plus blank (10,11,12,15). start → IDLE.
- LOSE: display "--" plus the final score (13,13,score tens,score ones). start → IDLE.
- hit in WIN or LOSE is ignored. Score and time hold their values until the next entry to RUN.
- Arithmetic: time and score are each two 4-bit BCD digits. No binary-to-BCD conversion is needed. WIN_SCORE and START_SEC are split into tens/ones at elaboration.

## Timing
- Every state change and display change becomes visible on the clk edge after the causing input cycle (latency 1).
- The first decrement occurs TICK_DIV cycles after the RUN-entry edge.
- Simultaneous hit and final tick in the same cycle: the score increments, the time decrements, and WIN takes priority over LOSE.
- rst asserted mid-round returns all state to reset values on the next edge, regardless of the other inputs.
- In WIN and LOSE, val1/val0 and the time registers stay stable until the next start.

## Configuration
- SCORE_TIMER_PAUSE_EN defined:
  - start in RUN → PAUSE (encoded as state=1; internal flag set).
  - In PAUSE the tick counter is frozen, hit is ignored, and the display is unchanged.
  - start in PAUSE resumes RUN with the tick counter kept at its prior value.
- SCORE_TIMER_PAUSE_EN undefined: start in RUN is ignored and there is no pause logic.

## Test plan
All scenarios use TICK_DIV=4, START_SEC=3, WIN_SCORE=2.
- Reset then idle → val=13,13,13,13 and state=0. A hit pulse changes nothing.
- start → next edge state=1, val=0,3,0,0. After 4 cycles val3..val2=0,2. After 12 cycles total the display is "--00" and state=3.
- In RUN, two hit pulses before the first tick → after the first, val1..val0=0,1. After the second, state=2 and val=10,11,12,15.
- Hit on the same cycle as the tick that brings time to 00, with score at 1 → state=2 (WIN), not LOSE.
- START_SEC=12, WIN_SCORE=99: 11 hits then ticks → score reads 1,1 (BCD carry). The time sequence is 12, 11, 10, 09 (BCD borrow).
- rst mid-RUN → next edge state=0 and val=13,13,13,13. A following start reloads time 0,3 with score 0,0.
- With SCORE_TIMER_PAUSE_EN: start in RUN, wait 20 cycles → time unchanged and hits ignored. A second start resumes the count from the saved tick phase.
